// File: rtl/tdc_measure_sequencer.sv
// Sequencer for one gated edge-count measurement: clear, gate, settle, capture, valid/ready result.
// Optional TDC_AUTO_REARM_EN: back-to-back measurements while start stays high, with lost-result pulse.
module tdc_measure_sequencer #(
    parameter int GATE_W       = 16,
    parameter int CNT_W        = 8,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              inc,
    input  logic [CNT_W-1:0]  count_in,
    output logic              cnt_clear,
    output logic              cnt_en,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  result,
    output logic              overflow,
    output logic              lost
);

    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

`ifdef TDC_AUTO_REARM_EN
    localparam bit AUTO_REARM = 1'b1;
`else
    localparam bit AUTO_REARM = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_SETTLE,
        S_CAPTURE
    } state_t;

    state_t             state_q, state_d;
    logic [CLR_W-1:0]   clr_cnt_q;
    logic [GATE_W-1:0]  gate_cnt_q;
    logic               trk_q;
    logic               cnt_clear_q, cnt_clear_d;
    logic               cnt_en_q, cnt_en_d;
    logic               busy_q, busy_d;
    logic               res_valid_q;
    logic [CNT_W-1:0]   result_q;
    logic               overflow_q;
    logic               start_ok;
    logic               load;
    logic               capture;

    // With auto-rearm a pending result does not block a new start; it gets overwritten instead.
    assign start_ok = start & (AUTO_REARM | ~res_valid_q);
    assign load     = (state_d == S_CLEAR) && ((state_q == S_IDLE) || (state_q == S_CAPTURE));
    assign capture  = (state_q == S_CAPTURE) && !abort;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_ok && !abort) state_d = S_CLEAR;
            S_CLEAR:   if (clr_cnt_q == '0) state_d = S_GATE;
            S_GATE:    if (gate_cnt_q <= GATE_W'(1)) state_d = S_SETTLE;
            S_SETTLE:  state_d = S_CAPTURE;
            S_CAPTURE: state_d = (AUTO_REARM && start) ? S_CLEAR : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    always_comb begin
        cnt_clear_d = (state_d == S_CLEAR);
        cnt_en_d    = (state_d == S_GATE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            clr_cnt_q   <= '0;
            gate_cnt_q  <= '0;
            trk_q       <= 1'b0;
            cnt_clear_q <= 1'b0;
            cnt_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_clear_q <= cnt_clear_d;
            cnt_en_q    <= cnt_en_d;
            busy_q      <= busy_d;

            if (load) begin
                gate_cnt_q <= (gate_len == '0) ? GATE_W'(1) : gate_len;
                clr_cnt_q  <= CLR_W'(CLEAR_CYCLES - 1);
            end else if (state_q == S_CLEAR) begin
                trk_q <= 1'b0;
                if (clr_cnt_q != '0) clr_cnt_q <= clr_cnt_q - 1'b1;
            end else if (state_q == S_GATE) begin
                gate_cnt_q <= gate_cnt_q - 1'b1;
                if (cnt_en_q && inc && (&count_in)) trk_q <= 1'b1;
            end

            // Capture wins over a simultaneous acceptance so the new result is not dropped.
            if (capture) begin
                res_valid_q <= 1'b1;
                result_q    <= count_in;
                overflow_q  <= trk_q;
            end else if (res_valid_q && res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

`ifdef TDC_AUTO_REARM_EN
    logic lost_q;

    always_ff @(posedge clk) begin
        if (rst) lost_q <= 1'b0;
        else     lost_q <= capture & res_valid_q & ~res_ready;
    end

    assign lost = lost_q;
`else
    assign lost = 1'b0;
`endif

    assign cnt_clear = cnt_clear_q;
    assign cnt_en    = cnt_en_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;

endmodule
